rgb_fade_sequencer: RTL

RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

---
 rtl/rgb_fade_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rgb_fade_sequencer.sv
// RGB hue-wheel fader: ramps one channel at a time through six phases and
// drives three active-low PWM LED outputs from period-aligned duty registers.
module rgb_fade_sequencer #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned STEP_CYCLES  = 12000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       hold,
    input  logic       restart,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] phase,
    output logic       phase_done
);

    localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] LAST      = DW'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        PH_GREEN_INC = 3'd0,
        PH_RED_DEC   = 3'd1,
        PH_BLUE_INC  = 3'd2,
        PH_GREEN_DEC = 3'd3,
        PH_RED_INC   = 3'd4,
        PH_BLUE_DEC  = 3'd5
    } phase_t;

    logic [DW-1:0] r_pwm_cnt;
    logic [SW-1:0] r_step_cnt;
    logic [DW-1:0] r_ramp;
    phase_t        r_phase;
    logic [DW-1:0] r_duty_r;
    logic [DW-1:0] r_duty_g;
    logic [DW-1:0] r_duty_b;

    logic          w_run;
    logic          w_step_tick;
    logic          w_ramp_wrap;
    logic          w_pwm_last;
    logic [DW-1:0] w_ramp_inv;
    logic [DW-1:0] w_tgt_r;
    logic [DW-1:0] w_tgt_g;
    logic [DW-1:0] w_tgt_b;

    assign w_run       = enable && !hold;
    assign w_step_tick = w_run && !restart && (r_step_cnt == STEP_LAST);
    assign w_ramp_wrap = w_step_tick && (r_ramp == LAST);
    assign w_pwm_last  = (r_pwm_cnt == LAST);
    // r_ramp never exceeds LAST, so this never underflows
    assign w_ramp_inv  = FULL - r_ramp;
    assign phase       = r_phase;

    // Free-running PWM period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else if (w_pwm_last) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + DW'(1);
        end
    end

    // Step timer and ramp counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
            r_ramp     <= '0;
        end else if (restart) begin
            r_step_cnt <= '0;
            r_ramp     <= '0;
        end else if (w_run) begin
            r_step_cnt <= w_step_tick ? '0 : r_step_cnt + SW'(1);
            if (w_step_tick) begin
                r_ramp <= w_ramp_wrap ? '0 : r_ramp + DW'(1);
            end
        end
    end

    // Hue phase state machine; unused encodings fall back to phase 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= PH_GREEN_INC;
            phase_done <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            if (restart) begin
                r_phase <= PH_GREEN_INC;
            end else begin
                case (r_phase)
                    PH_GREEN_INC: if (w_ramp_wrap) r_phase <= PH_RED_DEC;
                    PH_RED_DEC:   if (w_ramp_wrap) r_phase <= PH_BLUE_INC;
                    PH_BLUE_INC:  if (w_ramp_wrap) r_phase <= PH_GREEN_DEC;
                    PH_GREEN_DEC: if (w_ramp_wrap) r_phase <= PH_RED_INC;
                    PH_RED_INC:   if (w_ramp_wrap) r_phase <= PH_BLUE_DEC;
                    PH_BLUE_DEC:  if (w_ramp_wrap) r_phase <= PH_GREEN_INC;
                    default:      r_phase <= PH_GREEN_INC;
                endcase
                phase_done <= w_ramp_wrap;
            end
        end
    end

    // Per-phase channel duty targets
    always_comb begin
        w_tgt_r = '0;
        w_tgt_g = '0;
        w_tgt_b = '0;
        case (r_phase)
            PH_GREEN_INC: begin w_tgt_r = FULL;       w_tgt_g = r_ramp;     end
            PH_RED_DEC:   begin w_tgt_r = w_ramp_inv; w_tgt_g = FULL;       end
            PH_BLUE_INC:  begin w_tgt_g = FULL;       w_tgt_b = r_ramp;     end
            PH_GREEN_DEC: begin w_tgt_g = w_ramp_inv; w_tgt_b = FULL;       end
            PH_RED_INC:   begin w_tgt_r = r_ramp;     w_tgt_b = FULL;       end
            PH_BLUE_DEC:  begin w_tgt_r = FULL;       w_tgt_b = w_ramp_inv; end
            default:      ;
        endcase
    end

    // Duties only change at the period boundary to avoid glitched periods
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_r <= '0;
            r_duty_g <= '0;
            r_duty_b <= '0;
        end else if (w_pwm_last) begin
            r_duty_r <= w_tgt_r;
            r_duty_g <= w_tgt_g;
            r_duty_b <= w_tgt_b;
        end
    end

    // Active-low registered LED drives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RGB_R <= 1'b1;
            RGB_G <= 1'b1;
            RGB_B <= 1'b1;
        end else begin
            RGB_R <= ~(enable && (r_pwm_cnt < r_duty_r));
            RGB_G <= ~(enable && (r_pwm_cnt < r_duty_g));
            RGB_B <= ~(enable && (r_pwm_cnt < r_duty_b));
        end
    end

endmodule
